// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC XOR global history indexes a table of saturating
// counters. Registered one-cycle prediction, speculative history, mispredict repair.
module gshare_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 8,
  parameter int PC_LSB     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  pred_req,
  input  logic [15:0]           pred_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [HIST_BITS-1:0]  pred_hist,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [HIST_BITS-1:0]  upd_hist
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]   CTR_MIN  = '0;
  localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MIN) ? c : c - 1'b1;
  endfunction

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
  logic [HIST_BITS-1:0]    ghr_q, ghr_d;
  logic                    pvld_q, pvld_d;
  logic                    ptkn_q, ptkn_d;
  logic [INDEX_BITS-1:0]   pidx_q, pidx_d;
  logic [HIST_BITS-1:0]    phist_q, phist_d;

  logic [CTR_BITS-1:0]     tbl_q [DEPTH];
  logic                    tbl_we;
  logic [INDEX_BITS-1:0]   tbl_waddr;
  logic [CTR_BITS-1:0]     tbl_wdata;

  logic [INDEX_BITS-1:0]   idx_pred;
  logic [CTR_BITS-1:0]     ctr_pred;
  logic [CTR_BITS-1:0]     ctr_upd;
  logic                    unused_pc_bits;

  // Only a slice of the PC reaches the index; the rest is deliberately dropped.
  assign unused_pc_bits = ^pred_pc;

  assign idx_pred = pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr_q);
  assign ctr_pred = tbl_q[idx_pred];
  assign ctr_upd  = tbl_q[upd_index];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ghr_d     = ghr_q;
    pvld_d    = 1'b0;
    ptkn_d    = ptkn_q;
    pidx_d    = pidx_q;
    phist_d   = phist_q;
    tbl_we    = 1'b0;
    tbl_waddr = ptr_q;
    tbl_wdata = CTR_WEAK;
    case (state_q)
      S_INIT: begin
        tbl_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (pred_req) begin
          pvld_d  = 1'b1;
          ptkn_d  = ctr_pred[CTR_BITS-1];
          pidx_d  = idx_pred;
          phist_d = ghr_q;
          ghr_d   = {ghr_q[HIST_BITS-2:0], ctr_pred[CTR_BITS-1]};
        end
        if (upd_valid) begin
          tbl_we    = 1'b1;
          tbl_waddr = upd_index;
          tbl_wdata = upd_taken ? sat_inc(ctr_upd) : sat_dec(ctr_upd);
          // Repair wins over the speculative shift issued in the same cycle.
          if (upd_mispredict) ghr_d = {upd_hist[HIST_BITS-2:0], upd_taken};
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      pvld_q  <= 1'b0;
      ptkn_q  <= 1'b0;
      pidx_q  <= '0;
      phist_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      pvld_q  <= pvld_d;
      ptkn_q  <= ptkn_d;
      pidx_q  <= pidx_d;
      phist_q <= phist_d;
    end
  end

  // Counter storage is not reset; the init walk rewrites every entry.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  assign ready      = (state_q == S_RUN);
  assign pred_valid = pvld_q;
  assign pred_taken = ptkn_q;
  assign pred_index = pidx_q;
  assign pred_hist  = phist_q;

endmodule
